// File: rtl/sw_test_status_pkg.sv
// rtl/sw_test_status_pkg.sv - test-status codes, field widths and transition rules
package sw_test_status_pkg;

  localparam int StatusIdxW = 8;
  localparam int StatusCntW = 8;

  typedef enum logic [15:0] {
    ST_UNDEF   = 16'h0000,
    ST_BOOTROM = 16'hb090,
    ST_BOOTED  = 16'hb004,
    ST_IN_TEST = 16'h4354,
    ST_IN_WFI  = 16'h1d1e,
    ST_PASSED  = 16'h900d,
    ST_FAILED  = 16'hbaad
  } sw_test_status_e;

  // Rewriting the current code is accepted so that index and count still advance.
  function automatic logic is_legal_transition(sw_test_status_e cur, logic [15:0] nxt);
    logic ok;
    ok = 1'b0;
    if (cur == ST_PASSED || cur == ST_FAILED) begin
      ok = 1'b0;
    end else if (nxt == cur || nxt == ST_FAILED) begin
      ok = 1'b1;
    end else begin
      case (cur)
        ST_UNDEF:   ok = (nxt == ST_BOOTROM);
        ST_BOOTROM: ok = (nxt == ST_BOOTED);
        ST_BOOTED:  ok = (nxt == ST_IN_TEST);
        ST_IN_TEST: ok = (nxt == ST_IN_WFI) || (nxt == ST_PASSED);
        ST_IN_WFI:  ok = (nxt == ST_IN_TEST);
        default:    ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/sw_test_status_rr_arb.sv
// rtl/sw_test_status_rr_arb.sv - round-robin single-grant arbiter with rotating pointer
module sw_test_status_rr_arb #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid
);

  localparam int PtrW = $clog2(N);

  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] cand;

  // Walk the requesters starting at the pointer; the first active one wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
      cand = (cand == PtrW'(N - 1)) ? '0 : cand + 1'b1;
    end
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (gnt_valid) begin
      ptr_q <= (gnt_idx == PtrW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sw_test_status_ctrl.sv
// rtl/sw_test_status_ctrl.sv - arbitrated, sequence-checked software test-status word
module sw_test_status_ctrl
  import sw_test_status_pkg::*;
#(
  parameter int          NumReq        = 4,
  parameter int unsigned TimeoutCycles = 32'd100000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumReq-1:0]    req_i,
  input  logic [NumReq*16-1:0] code_i,
  output logic [NumReq-1:0]    gnt_o,
  output logic [31:0]          status_o,
  output logic                 passed_o,
  output logic                 failed_o,
  output logic                 timeout_o,
  output logic                 illegal_o
);

  localparam int IdxW = $clog2(NumReq);

  logic [IdxW-1:0]       gnt_idx;
  logic                  gnt_valid;
  logic [15:0]           wr_code;
  logic                  accept;
  logic                  running;
  logic                  expire;

  sw_test_status_e       state_q, state_d;
  logic [StatusIdxW-1:0] idx_q, idx_d;
  logic [StatusCntW-1:0] cnt_q, cnt_d;
  logic [31:0]           tmo_q, tmo_d;
  logic                  passed_q, failed_q, timeout_q, illegal_q;
  logic                  timeout_d;

  sw_test_status_rr_arb #(.N(NumReq)) u_arb (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .req       (req_i),
    .gnt       (gnt_o),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    wr_code = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (gnt_o[k]) wr_code = code_i[16*k +: 16];
    end
  end

  assign accept  = gnt_valid && is_legal_transition(state_q, wr_code);
  assign running = (state_q == ST_IN_TEST) || (state_q == ST_IN_WFI);
  // An accepted write on the expiry cycle takes priority over the timeout.
  assign expire  = (TimeoutCycles != 0) && running && !accept &&
                   (tmo_q == 32'(TimeoutCycles - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tmo_d     = '0;
    timeout_d = timeout_q;
    if (accept) begin
      state_d = sw_test_status_e'(wr_code);
      idx_d   = StatusIdxW'(gnt_idx);
      cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end else if (expire) begin
      state_d   = ST_FAILED;
      timeout_d = 1'b1;
    end else if (running) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_UNDEF;
      idx_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      passed_q  <= 1'b0;
      failed_q  <= 1'b0;
      timeout_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      passed_q  <= passed_q | (state_d == ST_PASSED);
      failed_q  <= failed_q | (state_d == ST_FAILED);
      timeout_q <= timeout_d;
      illegal_q <= gnt_valid && !accept;
    end
  end

  assign status_o  = {cnt_q, idx_q, state_q};
  assign passed_o  = passed_q;
  assign failed_o  = failed_q;
  assign timeout_o = timeout_q;
  assign illegal_o = illegal_q;

endmodule

// File: doc/sw_test_status_ctrl.md
Name: sw_test_status_ctrl

Overview:
Arbitrates software test-status writes from up to NumReq requesters (cores, DMA, debug) onto the single 32-bit word driven into sw_test_status_if.x.
- Enforces the legal test-status sequence with an FSM.
- Makes PASSED/FAILED sticky.
- Declares FAILED on a progress timeout.
- Sits between the requesters and the status interface instance in the top level.

Parameters:
- NumReq, 4: number of requesters (2..16).
- TimeoutCycles, 32'd100000: cycles allowed in IN_TEST/IN_WFI without an accepted write; 0 disables the timeout.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- req_i  input  NumReq  write request per requester; held high until granted
- code_i  input  NumReq*16  flattened status codes; requester k uses bits [16k+15:16k]
- gnt_o  output  NumReq  one-hot grant, combinational from req_i and the rr pointer
- status_o  output  32  status word, wired to sw_test_status_if.x
- passed_o  output  1  sticky, set on entry to PASSED
- failed_o  output  1  sticky, set on entry to FAILED
- timeout_o  output  1  sticky, set when FAILED is caused by the timeout
- illegal_o  output  1  one-cycle pulse, cycle after an illegal or ignored write

Behaviour:
Clock and reset:
- One clock; reset is asynchronous and active-low (clk_i, rst_ni).

Reset values:
- status_o = 32'h0, which is code UNDEF with index 0 and count 0.
- passed_o, failed_o, timeout_o, illegal_o = 0.
- rr pointer = 0, timeout counter = 0, FSM = UNDEF.

Arbitration:
- Round-robin arbitration, at most one grant per cycle.
- Search starts at the rr pointer. After a grant, the pointer becomes winner+1 mod NumReq.
- If no request is active, the pointer does not move.
- The granted requester's code is sampled in the grant cycle; the requester drops req_i the next cycle.

Status word:
- Updated the cycle after the grant (1-cycle latency).
- status_o[15:0] = current state code.
- status_o[23:16] = index of the last accepted writer.
- status_o[31:24] = accepted-write count, saturating at 8'hFF.

FSM states and codes (from the package):
- UNDEF 16'h0000
- BOOTROM 16'hb090
- BOOTED 16'hb004
- IN_TEST 16'h4354
- IN_WFI 16'h1d1e
- PASSED 16'h900d
- FAILED 16'hbaad

Legal transitions:
- UNDEF -> BOOTROM
- BOOTROM -> BOOTED
- BOOTED -> IN_TEST
- IN_TEST <-> IN_WFI
- IN_TEST -> PASSED
- any non-terminal state -> FAILED
- writing the current code again is legal: only the count and index update.

Illegal writes:
- Any other code, or an unknown code, is illegal.
- The write is still granted, so the requester is not stalled.
- State, code, index and count are unchanged; illegal_o pulses.

Terminal states:
- PASSED and FAILED are terminal.
- Later writes are granted and ignored, and illegal_o pulses.
- Only reset leaves a terminal state.

Timeout:
- The counter runs only in IN_TEST or IN_WFI and clears on every accepted write.
- When the counter reaches TimeoutCycles-1 with no write accepted that cycle, the next state is FAILED and timeout_o = 1.
- status_o[15:0] becomes 16'hbaad, with index and count unchanged.
- If an accepted write and expiry happen in the same cycle, the write wins and the counter clears.

Reset mid-operation:
- Asserting reset mid-operation immediately returns all outputs to their reset values.

Decomposition:
- Package sw_test_status_pkg holds:
  - typedef enum logic [15:0] sw_test_status_e with the seven codes above;
  - function is_legal_transition(cur, nxt);
  - localparam StatusIdxW = 8 and StatusCntW = 8.
- Sub-module sw_test_status_rr_arb (parameter N) implements the round-robin grant and pointer.
- The FSM, timeout counter and word packing live in sw_test_status_ctrl.

Test Plan:
- Reset, then requester 0 writes b090, b004, 4354, 900d in sequence:
  - status_o ends at 32'h0400_900d;
  - passed_o = 1, failed_o = 0.
- Requesters 0, 1, 2 all assert req_i with code b090 from UNDEF:
  - grants go to 0, 1, 2 in consecutive cycles;
  - final status_o = 32'h0302_b090.
- In BOOTED, a write of 900d:
  - illegal_o pulses for one cycle;
  - status_o[15:0] stays b004 and the count is unchanged.
- TimeoutCycles=16, reach IN_TEST, then no writes:
  - exactly 16 cycles after entry, status_o[15:0] = baad;
  - failed_o = 1, timeout_o = 1.
- TimeoutCycles=16, a write of 1d1e accepted on the expiry cycle:
  - state is IN_WFI, timeout_o = 0;
  - the counter restarts from 0.
- After FAILED, a write of 4354, then rst_ni pulsed low mid-cycle:
  - the 4354 write is ignored and illegal_o pulses;
  - the asynchronous reset clears status_o to 0 and all flags without waiting for a clock edge.
